// File: rtl/cnt_updn_ift_if.sv
// Signal bundle for the taint-tracked up/down counter: data/control inputs with
// their 32-bit taint labels, plus the counter value, terminal count and sticky flag.
interface cnt_updn_ift_if #(
    parameter int WIDTH = 4
);
    logic [31:0]      CLK_t;
    logic [31:0]      ARST_t;
    logic             EN;
    logic [31:0]      EN_t;
    logic             LD;
    logic [31:0]      LD_t;
    logic             DIR;
    logic [31:0]      DIR_t;
    logic [WIDTH-1:0] D;
    logic [31:0]      D_t;
    logic [WIDTH-1:0] Q;
    logic [31:0]      Q_t;
    logic             TC;
    logic [31:0]      TC_t;
    logic             TAINTED;

    modport master (
        output CLK_t, ARST_t, EN, EN_t, LD, LD_t, DIR, DIR_t, D, D_t,
        input  Q, Q_t, TC, TC_t, TAINTED
    );

    modport slave (
        input  CLK_t, ARST_t, EN, EN_t, LD, LD_t, DIR, DIR_t, D, D_t,
        output Q, Q_t, TC, TC_t, TAINTED
    );
endinterface

// File: rtl/cnt_updn_ift.sv
// Taint-instrumented up/down counter with async reset, enable and synchronous load.
// Define IFT_IMPLICIT_FLOW_EN to also track the hold decision as a flow into Q_t.
module cnt_updn_ift #(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] RST_VALUE    = '0,
    parameter logic             CLK_POLARITY = 1'b1,
    parameter logic             EN_POLARITY  = 1'b1,
    parameter logic             LD_POLARITY  = 1'b1
) (
    input  logic           CLK,
    input  logic           ARST,
    cnt_updn_ift_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = 1;

    logic             clk_act;
    logic             en_act;
    logic             ld_act;
    logic             d_is_x;
    logic             at_wrap;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]      qt_q, qt_d;
    logic             tainted_q, tainted_d;
    logic             unused_clk_t;

    assign clk_act      = CLK_POLARITY ? CLK : ~CLK;
    assign en_act       = (bus.EN == EN_POLARITY);
    assign ld_act       = (bus.LD == LD_POLARITY);
    // An unknown load value must not carry a label forward.
    assign d_is_x       = (^bus.D === 1'bx);
    assign unused_clk_t = ^bus.CLK_t;

    always_comb begin
        cnt_d = cnt_q;
        qt_d  = qt_q;
        if (ld_act) begin
            cnt_d = bus.D;
            qt_d  = d_is_x ? 32'h0 : (bus.D_t | bus.LD_t);
        end else if (en_act) begin
            cnt_d = bus.DIR ? (cnt_q + ONE) : (cnt_q - ONE);
            qt_d  = qt_q | bus.EN_t | bus.LD_t | bus.DIR_t;
        end else begin
`ifdef IFT_IMPLICIT_FLOW_EN
            qt_d  = qt_q | bus.EN_t | bus.LD_t;
`else
            qt_d  = qt_q;
`endif
        end
        tainted_d = tainted_q | (qt_d != 32'h0);
    end

    always_ff @(posedge clk_act or posedge ARST) begin
        if (ARST) begin
            cnt_q     <= RST_VALUE;
            qt_q      <= bus.ARST_t;
            tainted_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            qt_q      <= qt_d;
            tainted_q <= tainted_d;
        end
    end

    assign at_wrap     = bus.DIR ? (cnt_q == {WIDTH{1'b1}}) : (cnt_q == {WIDTH{1'b0}});
    assign bus.TC      = en_act & ~ld_act & at_wrap;
    assign bus.TC_t    = qt_q | bus.EN_t | bus.LD_t | bus.DIR_t;
    assign bus.Q       = cnt_q;
    assign bus.Q_t     = qt_q;
    assign bus.TAINTED = tainted_q;

endmodule

// File: tb/tb_cnt_updn_ift.sv
// Self-checking bench for cnt_updn_ift: vector table for single-cycle behaviour,
// hand-written sequences for X-load, mid-count reset and hold-cycle taint.
module tb_cnt_updn_ift;
    localparam int W = 4;
`ifdef IFT_IMPLICIT_FLOW_EN
    localparam bit IMPL = 1'b1;
`else
    localparam bit IMPL = 1'b0;
`endif

    logic CLK = 1'b0;
    logic ARST;

    cnt_updn_ift_if #(.WIDTH(W)) bus ();

    cnt_updn_ift #(.WIDTH(W)) dut (
        .CLK  (CLK),
        .ARST (ARST),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic         ld;
        logic [31:0]  ld_t;
        logic         en;
        logic [31:0]  en_t;
        logic         dir;
        logic [31:0]  dir_t;
        logic [W-1:0] d;
        logic [31:0]  d_t;
        logic         tc;
        logic [31:0]  tc_t;
        logic [W-1:0] q;
        logic [31:0]  q_t;
        logic         tnt;
    } vec_t;

    typedef struct {
        string        name;
        logic         chk_q;
        logic [W-1:0] q;
        logic [31:0]  q_t;
        logic         tnt;
    } exp_t;

    vec_t vecs[15];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic ld, input logic [31:0] ld_t,
                                input logic en, input logic [31:0] en_t,
                                input logic dir, input logic [31:0] dir_t,
                                input logic [W-1:0] d, input logic [31:0] d_t,
                                input logic tc, input logic [31:0] tc_t,
                                input logic [W-1:0] q, input logic [31:0] q_t,
                                input logic tnt);
        vec_t v;
        v.ld = ld;   v.ld_t = ld_t; v.en = en;   v.en_t = en_t;
        v.dir = dir; v.dir_t = dir_t; v.d = d;   v.d_t = d_t;
        v.tc = tc;   v.tc_t = tc_t; v.q = q;     v.q_t = q_t; v.tnt = tnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.LD    = v.ld;  bus.LD_t  = v.ld_t;
        bus.EN    = v.en;  bus.EN_t  = v.en_t;
        bus.DIR   = v.dir; bus.DIR_t = v.dir_t;
        bus.D     = v.d;   bus.D_t   = v.d_t;
    endtask

    // Drive at the falling edge, check combinational TC before the rising edge,
    // then compare registered outputs against the queued expectation after it.
    task automatic step(input string name, input vec_t v, input logic chk_q);
        exp_t e;
        @(negedge CLK);
        drive(v);
        #1;
        chk({name, ".tc"},   32'(bus.TC), 32'(v.tc));
        chk({name, ".tc_t"}, bus.TC_t, v.tc_t);
        e.name = name; e.chk_q = chk_q; e.q = v.q; e.q_t = v.q_t; e.tnt = v.tnt;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            chk({name, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (e.chk_q) chk({e.name, ".q"}, 32'(bus.Q), 32'(e.q));
            chk({e.name, ".q_t"}, bus.Q_t, e.q_t);
            chk({e.name, ".tainted"}, 32'(bus.TAINTED), 32'(e.tnt));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] xv;
        logic         is4;
        logic [31:0]  x_qt;
        logic [31:0]  h_qt;

        xv  = 4'bx1x0;
        is4 = (^xv === 1'bx);
        x_qt = is4 ? 32'h0 : 32'hFF;
        h_qt = IMPL ? 32'h48 : 32'h40;

        //            ld ld_t    en ent      dir dirt   d     d_t       tc tc_t                   q     q_t                   tnt
        vecs[0]  = mk(0, 32'h0,  0, 32'h0,   0, 32'h0, 4'h0, 32'h0,    0, 32'h1,                 4'h0, 32'h1,                1);
        vecs[1]  = mk(1, 32'h2,  0, 32'h0,   0, 32'h0, 4'h9, 32'h10,   0, 32'h3,                 4'h9, 32'h12,               1);
        vecs[2]  = mk(1, 32'h0,  0, 32'h0,   0, 32'h0, 4'hE, 32'h0,    0, 32'h12,                4'hE, 32'h0,                1);
        vecs[3]  = mk(0, 32'h0,  1, 32'h100, 1, 32'h0, 4'h0, 32'h0,    0, 32'h100,               4'hF, 32'h100,              1);
        vecs[4]  = mk(0, 32'h0,  1, 32'h100, 1, 32'h0, 4'h0, 32'h0,    1, 32'h100,               4'h0, 32'h100,              1);
        vecs[5]  = mk(0, 32'h0,  1, 32'h100, 1, 32'h0, 4'h0, 32'h0,    0, 32'h100,               4'h1, 32'h100,              1);
        vecs[6]  = mk(1, 32'h0,  0, 32'h0,   0, 32'h0, 4'h1, 32'h0,    0, 32'h100,               4'h1, 32'h0,                1);
        vecs[7]  = mk(0, 32'h0,  1, 32'h0,   0, 32'h4, 4'h0, 32'h0,    0, 32'h4,                 4'h0, 32'h4,                1);
        vecs[8]  = mk(0, 32'h0,  1, 32'h0,   0, 32'h4, 4'h0, 32'h0,    1, 32'h4,                 4'hF, 32'h4,                1);
        vecs[9]  = mk(0, 32'h0,  1, 32'h0,   0, 32'h4, 4'h0, 32'h0,    0, 32'h4,                 4'hE, 32'h4,                1);
        vecs[10] = mk(1, 32'h0,  1, 32'h0,   1, 32'h0, 4'h3, 32'h0,    0, 32'h4,                 4'h3, 32'h0,                1);
        vecs[11] = mk(0, 32'h0,  0, 32'h8,   1, 32'h0, 4'h0, 32'h0,    0, 32'h8,                 4'h3, IMPL ? 32'h8 : 32'h0, 1);
        vecs[12] = mk(1, 32'h20, 1, 32'h0,   0, 32'h0, 4'hF, 32'h0,    0, IMPL ? 32'h28 : 32'h20, 4'hF, 32'h20,              1);
        vecs[13] = mk(0, 32'h0,  0, 32'h0,   1, 32'h0, 4'h0, 32'h0,    0, 32'h20,                4'hF, 32'h20,               1);
        vecs[14] = mk(0, 32'h0,  1, 32'h0,   1, 32'h0, 4'h0, 32'h0,    1, 32'h20,                4'h0, 32'h20,               1);

        // Reset takes effect without any clock edge.
        bus.CLK_t  = 32'h0;
        bus.ARST_t = 32'h1;
        drive(mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0));
        ARST = 1'b1;
        #1;
        chk("reset.q",       32'(bus.Q), 32'h0);
        chk("reset.q_t",     bus.Q_t, 32'h1);
        chk("reset.tainted", 32'(bus.TAINTED), 32'h0);
        chk("reset.tc",      32'(bus.TC), 32'h0);
        chk("reset.tc_t",    bus.TC_t, 32'h1);
        @(negedge CLK);
        ARST = 1'b0;

        for (int i = 0; i < 15; i++) begin
            step($sformatf("vec%0d", i), vecs[i], 1'b1);
        end

        // Unknown load data drops the label (only observable on a 4-state simulator).
        step("xload", mk(1, 32'h0, 0, 32'h0, 0, 32'h0, xv, 32'hFF, 0, 32'h20, 4'h0, x_qt, 1), 1'b0);

        step("mid.ld5", mk(1, 0, 0, 0, 0, 0, 4'h5, 0, 0, x_qt,  4'h5, 32'h0, 1), 1'b1);
        step("mid.up6", mk(0, 0, 1, 0, 1, 0, 4'h0, 0, 0, 32'h0, 4'h6, 32'h0, 1), 1'b1);
        step("mid.up7", mk(0, 0, 1, 0, 1, 0, 4'h0, 0, 0, 32'h0, 4'h7, 32'h0, 1), 1'b1);

        #2;
        bus.ARST_t = 32'h40;
        ARST = 1'b1;
        #1;
        chk("midrst.q",       32'(bus.Q), 32'h0);
        chk("midrst.q_t",     bus.Q_t, 32'h40);
        chk("midrst.tainted", 32'(bus.TAINTED), 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        chk("rsthold.q",       32'(bus.Q), 32'h0);
        chk("rsthold.q_t",     bus.Q_t, 32'h40);
        chk("rsthold.tainted", 32'(bus.TAINTED), 32'h0);
        ARST = 1'b0;

        step("hold1", mk(0, 0, 0, 32'h8, 1, 0, 4'h0, 0, 0, 32'h48, 4'h0, h_qt, 1), 1'b1);
        step("hold2", mk(0, 0, 0, 32'h8, 1, 0, 4'h0, 0, 0, 32'h48, 4'h0, h_qt, 1), 1'b1);
        step("postrst.up", mk(0, 0, 1, 32'h0, 1, 0, 4'h0, 0, 0, h_qt, 4'h1, h_qt, 1), 1'b1);

        chk("sb.drained", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
